// File: rtl/noc_injector_pkg.sv
// Shared flit-format and injector FSM definitions for the NoC tile interface.
// Head flit payload, MSB first below the type bits: dest_x, dest_y, src_x, src_y.
package noc_pkg;

  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_type_t;

  localparam int COORD_W       = 4;
  localparam int HEAD_FIELDS_W = 4 * COORD_W;
  // Offsets within the head field block, counted from its LSB.
  localparam int DEST_X_OFS    = 3 * COORD_W;
  localparam int DEST_Y_OFS    = 2 * COORD_W;
  localparam int SRC_X_OFS     = 1 * COORD_W;
  localparam int SRC_Y_OFS     = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_H = 3'd1,
    WAIT   = 3'd2,
    LOAD   = 3'd3,
    SEND_B = 3'd4
  } inj_state_t;

  function automatic logic [HEAD_FIELDS_W-1:0] head_fields(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] sx,
    input logic [COORD_W-1:0] sy
  );
    logic [HEAD_FIELDS_W-1:0] f;
    f = '0;
    f[DEST_X_OFS +: COORD_W] = dx;
    f[DEST_Y_OFS +: COORD_W] = dy;
    f[SRC_X_OFS  +: COORD_W] = sx;
    f[SRC_Y_OFS  +: COORD_W] = sy;
    return f;
  endfunction

endpackage

// File: rtl/noc_injector_sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous level (the 2-phase ack).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/noc_injector.sv
// Packetizing injector: valid/ready words in, 2-phase bundled-data flits out.
// Optional counters (stat_pkts/stat_flits/stat_stall) enabled by NOC_INJECTOR_STATS_EN.
module noc_injector
  import noc_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int LocationX   = 2,
  parameter int LocationY   = 2,
  parameter int MAX_FLITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gen_enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-3:0] s_data,
  input  logic             s_last,
  input  logic [3:0]       dest_x,
  input  logic [3:0]       dest_y,
  output logic             req_o,
  output logic [WIDTH-1:0] Data_o,
  input  logic             ack_i
`ifdef NOC_INJECTOR_STATS_EN
  ,
  output logic [31:0]      stat_pkts,
  output logic [31:0]      stat_flits,
  output logic [31:0]      stat_stall
`endif
);

  localparam int PAD_W = WIDTH - 2 - HEAD_FIELDS_W;
  localparam logic [7:0] LAST_IDX = 8'(MAX_FLITS - 1);
  localparam logic [COORD_W-1:0] SRC_X = COORD_W'(LocationX);
  localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(LocationY);

  inj_state_t state;
  logic [7:0] flit_cnt;
  logic       tail_sent;
  logic       ack_sync;
  logic       is_tail;
  logic       ack_done;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_i),
    .q     (ack_sync)
  );

  assign s_ready  = (state == LOAD) && s_valid;
  // flit_cnt counts flits already sent in this packet, head included.
  assign is_tail  = s_last || (flit_cnt == LAST_IDX);
  assign ack_done = (state == WAIT) && (ack_sync == req_o);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_o     <= 1'b0;
      Data_o    <= '0;
      flit_cnt  <= '0;
      tail_sent <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gen_enable && s_valid) begin
            Data_o    <= {HEAD, head_fields(dest_x, dest_y, SRC_X, SRC_Y), {PAD_W{1'b0}}};
            flit_cnt  <= '0;
            tail_sent <= 1'b0;
            state     <= SEND_H;
          end
        end
        SEND_H: begin
          req_o    <= ~req_o;
          flit_cnt <= flit_cnt + 8'd1;
          state    <= WAIT;
        end
        WAIT: begin
          if (ack_sync == req_o) begin
            state <= tail_sent ? IDLE : LOAD;
          end
        end
        LOAD: begin
          // Data_o changes only here and in IDLE, a full cycle ahead of the req_o toggle.
          if (s_valid) begin
            Data_o    <= is_tail ? {TAIL, s_data} : {BODY, s_data};
            tail_sent <= is_tail;
            state     <= SEND_B;
          end
        end
        SEND_B: begin
          req_o    <= ~req_o;
          flit_cnt <= flit_cnt + 8'd1;
          state    <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_INJECTOR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pkts  <= '0;
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (ack_done && (stat_flits != '1)) begin
        stat_flits <= stat_flits + 32'd1;
      end
      if (ack_done && tail_sent && (stat_pkts != '1)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if ((state == WAIT) && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`else
  // ack_done only feeds the optional counters.
  logic unused_ack_done;
  assign unused_ack_done = ack_done;
`endif

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector: instance 0 uses MAX_FLITS=16, instance 1 MAX_FLITS=4.
// A switch-side model logs flits on each req toggle and answers with a delayed ack.
module tb_noc_injector;

  localparam int W    = 64;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           gen_enable [2];
  logic           s_valid    [2];
  logic           s_last     [2];
  logic [W-3:0]   s_data     [2];
  logic [3:0]     dest_x     [2];
  logic [3:0]     dest_y     [2];
  logic           s_ready    [2];
  logic           req        [2];
  logic           ack        [2];
  logic [W-1:0]   data       [2];
`ifdef NOC_INJECTOR_STATS_EN
  logic [31:0]    st_pkts    [2];
  logic [31:0]    st_flits   [2];
  logic [31:0]    st_stall   [2];
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    noc_injector #(
      .WIDTH       (W),
      .LocationX   (2),
      .LocationY   (2),
      .MAX_FLITS   ((gi == 0) ? 16 : 4),
      .SYNC_STAGES (SYNC)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .gen_enable (gen_enable[gi]),
      .s_valid    (s_valid[gi]),
      .s_ready    (s_ready[gi]),
      .s_data     (s_data[gi]),
      .s_last     (s_last[gi]),
      .dest_x     (dest_x[gi]),
      .dest_y     (dest_y[gi]),
      .req_o      (req[gi]),
      .Data_o     (data[gi]),
      .ack_i      (ack[gi])
`ifdef NOC_INJECTOR_STATS_EN
      ,
      .stat_pkts  (st_pkts[gi]),
      .stat_flits (st_flits[gi]),
      .stat_stall (st_stall[gi])
`endif
    );
  end

  // ---------------- switch-side model ----------------
  logic [W-1:0] flog0 [$];
  logic [W-1:0] flog1 [$];
  logic         manual   [2];
  logic         man_ack  [2];
  int           ack_dly  [2];
  int           viol     [2] = '{0, 0};
  int           wait_exp [2] = '{0, 0};
  logic         req_prev [2];
  logic [W-1:0] held     [2];
  int           dcnt     [2];

  always @(posedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ack[i]      = 1'b0;
        req_prev[i] = 1'b0;
        held[i]     = '0;
        dcnt[i]     = 0;
      end else begin
        if (req[i] !== req_prev[i]) begin
          if (i == 0) flog0.push_back(data[i]);
          else        flog1.push_back(data[i]);
          held[i]     = data[i];
          req_prev[i] = req[i];
          dcnt[i]     = 0;
        end
        if (req[i] !== ack[i]) begin
          if ((data[i] !== held[i]) || (s_ready[i] !== 1'b0)) viol[i]++;
          if (manual[i]) begin
            ack[i] = man_ack[i];
          end else if (dcnt[i] >= ack_dly[i]) begin
            ack[i] = req[i];
            wait_exp[i] += dcnt[i] + SYNC + 1;
          end else begin
            dcnt[i]++;
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s: got no event want event", name);
  endtask

  function automatic int flog_size(input int i);
    return (i == 0) ? flog0.size() : flog1.size();
  endfunction

  function automatic logic [63:0] flit_at(input int i, input int k);
    if (k >= flog_size(i)) return 64'h0;
    return (i == 0) ? flog0[k] : flog1[k];
  endfunction

  task automatic send_word(input int i, input logic [3:0] dx, input logic [3:0] dy,
                           input logic [W-3:0] d, input logic last);
    int t;
    dest_x[i]  = dx;
    dest_y[i]  = dy;
    s_data[i]  = d;
    s_last[i]  = last;
    s_valid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_ready[i] && t < 400);
    if (!s_ready[i]) timeout_fail("accept");
    @(negedge clk);
    s_valid[i] = 1'b0;
    s_last[i]  = 1'b0;
  endtask

  task automatic wait_flits(input int i, input int target);
    int t;
    t = 0;
    while (flog_size(i) < target && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (flog_size(i) < target) timeout_fail("flits");
  endtask

  task automatic wait_done(input int i, input int target);
    int t;
    wait_flits(i, target);
    t = 0;
    while (req[i] !== ack[i] && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (req[i] !== ack[i]) timeout_fail("ack");
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    man_ack[0] = 1'b0;
    man_ack[1] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]   dx;
    logic [3:0]   dy;
    int           nwords;
    int           dly;
    bit           drop_en;
    logic [W-3:0] base;
    logic [W-1:0] head;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input int i, input vec_t v, input string tag);
    int b, vb, n;
    n  = v.nwords;
    b  = flog_size(i);
    vb = viol[i];
    ack_dly[i] = v.dly;
    for (int w = 0; w < n; w++) begin
      send_word(i, v.dx, v.dy, v.base + 62'(w), (w == n - 1));
      if (v.drop_en && w == 0) gen_enable[i] = 1'b0;
    end
    wait_done(i, b + n + 1);
    chk({tag, "_nflits"}, 64'(flog_size(i) - b), 64'(n + 1));
    chk({tag, "_head"}, flit_at(i, b), v.head);
    for (int w = 0; w < n; w++) begin
      chk({tag, "_flit"}, flit_at(i, b + 1 + w),
          {((w == n - 1) ? 2'b10 : 2'b00), 62'(v.base + 62'(w))});
    end
    chk({tag, "_stable"}, 64'(viol[i] - vb), 64'd0);
    if (v.drop_en) begin
      b = flog_size(i);
      s_valid[i] = 1'b1;
      repeat (10) @(negedge clk);
      chk({tag, "_no_restart"}, 64'(flog_size(i) - b), 64'd0);
      s_valid[i] = 1'b0;
      gen_enable[i] = 1'b1;
    end
    $display("pkt %s: inst=%0d words=%0d flits_logged=%0d head=%h", tag, i, n, flog_size(i) - b, flit_at(i, b));
  endtask

  logic [W-1:0] ft_exp [10];

  initial begin
    int b, t, lat, hold_bad, ws;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gen_enable[i] = 1'b1;
      s_valid[i]    = 1'b0;
      s_last[i]     = 1'b0;
      s_data[i]     = '0;
      dest_x[i]     = '0;
      dest_y[i]     = '0;
      manual[i]     = 1'b0;
      man_ack[i]    = 1'b0;
      ack_dly[i]    = 1;
    end

    vecs[0] = '{dx: 4'd1,  dy: 4'd3,  nwords: 3, dly: 1,  drop_en: 1'b0, base: 62'h0A0,                head: 64'h44C8_8000_0000_0000};
    vecs[1] = '{dx: 4'd0,  dy: 4'd0,  nwords: 1, dly: 0,  drop_en: 1'b0, base: 62'h1B0,                head: 64'h4008_8000_0000_0000};
    vecs[2] = '{dx: 4'd15, dy: 4'd15, nwords: 2, dly: 20, drop_en: 1'b0, base: 62'h3FFF_FFFF_FFFF_FFF0, head: 64'h7FC8_8000_0000_0000};
    vecs[3] = '{dx: 4'd9,  dy: 4'd6,  nwords: 4, dly: 3,  drop_en: 1'b1, base: 62'h2AA0,               head: 64'h6588_8000_0000_0000};

    ft_exp[0] = 64'h44C8_8000_0000_0000;
    ft_exp[1] = {2'b00, 62'h101};
    ft_exp[2] = {2'b00, 62'h102};
    ft_exp[3] = {2'b10, 62'h103};
    ft_exp[4] = 64'h5488_8000_0000_0000;
    ft_exp[5] = {2'b00, 62'h104};
    ft_exp[6] = {2'b00, 62'h105};
    ft_exp[7] = {2'b10, 62'h106};
    ft_exp[8] = 64'h5488_8000_0000_0000;
    ft_exp[9] = {2'b00, 62'h107};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req",   64'(req[i]),     64'd0);
      chk("rst_data",  data[i],         64'd0);
      chk("rst_ready", 64'(s_ready[i]), 64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // gen_enable low blocks packet start
    gen_enable[0] = 1'b0;
    dest_x[0] = 4'd1;
    dest_y[0] = 4'd1;
    s_data[0] = 62'h5;
    s_valid[0] = 1'b1;
    b = flog_size(0);
    repeat (10) @(negedge clk);
    chk("gen_off_flits", 64'(flog_size(0) - b), 64'd0);
    chk("gen_off_ready", 64'(s_ready[0]), 64'd0);
    s_valid[0] = 1'b0;
    gen_enable[0] = 1'b1;
    @(negedge clk);

    // Table-driven packets
    for (int v = 0; v < 4; v++) begin
      run_vec(0, vecs[v], $sformatf("vec%0d", v));
    end

    // Slow ack with manual control: hold, then measure ack-to-ready latency
    man_ack[0] = ack[0];
    manual[0]  = 1'b1;
    b = flog_size(0);
    dest_x[0] = 4'd4;
    dest_y[0] = 4'd1;
    s_data[0] = 62'h777;
    s_last[0] = 1'b1;
    s_valid[0] = 1'b1;
    wait_flits(0, b + 1);
    chk("slow_head", flit_at(0, b), 64'h5048_8000_0000_0000);
    hold_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_ready[0] !== 1'b0 || data[0] !== 64'h5048_8000_0000_0000 || req[0] === ack[0]) hold_bad++;
    end
    chk("slow_hold", 64'(hold_bad), 64'd0);
    man_ack[0] = ~man_ack[0];
    @(posedge clk);
    #4;
    lat = 0;
    @(negedge clk);
    while (!s_ready[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("slow_latency", 64'(lat), 64'(SYNC + 1));
    @(negedge clk);
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    wait_flits(0, b + 2);
    chk("slow_tail", flit_at(0, b + 1), {2'b10, 62'h777});
    man_ack[0] = ~man_ack[0];
    repeat (6) @(negedge clk);
    manual[0] = 1'b0;
    $display("slow ack: latency=%0d hold_bad=%0d", lat, hold_bad);

    // Reset while waiting for an ack
    pulse_reset();
    manual[0]  = 1'b1;
    man_ack[0] = 1'b0;
    b = flog_size(0);
    dest_x[0] = 4'd1;
    dest_y[0] = 4'd3;
    s_data[0] = 62'h55;
    s_valid[0] = 1'b1;
    wait_flits(0, b + 1);
    repeat (2) @(negedge clk);
    chk("rst_wait_pre_req", 64'(req[0]), 64'd1);
    s_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_wait_req",   64'(req[0]),     64'd0);
    chk("rst_wait_data",  data[0],         64'd0);
    chk("rst_wait_ready", 64'(s_ready[0]), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    manual[0] = 1'b0;
    man_ack[0] = 1'b0;
    @(negedge clk);
    run_vec(0, vecs[0], "post_rst");

    // Forced tail on the MAX_FLITS=4 instance, dest re-sampled for the next packet
    ack_dly[1] = 1;
    b = flog_size(1);
    for (int k = 1; k <= 7; k++) begin
      if (k <= 3) send_word(1, 4'd1, 4'd3, 62'(62'h100 + 62'(k)), 1'b0);
      else        send_word(1, 4'd5, 4'd2, 62'(62'h100 + 62'(k)), 1'b0);
    end
    wait_flits(1, b + 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("forced_flit%0d", k), flit_at(1, b + k), ft_exp[k]);
    end
    $display("forced tail: %0d flits logged", flog_size(1) - b);

`ifdef NOC_INJECTOR_STATS_EN
    pulse_reset();
    ws = wait_exp[0];
    begin
      vec_t sa, sb;
      sa = '{dx: 4'd3, dy: 4'd7, nwords: 2, dly: 2, drop_en: 1'b0, base: 62'h900, head: 64'h4DC8_8000_0000_0000};
      sb = '{dx: 4'd1, dy: 4'd3, nwords: 4, dly: 2, drop_en: 1'b0, base: 62'hA00, head: 64'h44C8_8000_0000_0000};
      run_vec(0, sa, "stat_a");
      run_vec(0, sb, "stat_b");
    end
    chk("stat_pkts",      64'(st_pkts[0]),  64'd2);
    chk("stat_flits",     64'(st_flits[0]), 64'd8);
    chk("stat_stall",     64'(st_stall[0]), 64'(wait_exp[0] - ws));
    chk("stat_stall_abs", 64'(st_stall[0]), 64'd40);
    $display("stats: pkts=%0d flits=%0d stall=%0d", st_pkts[0], st_flits[0], st_stall[0]);
`else
    ws = 0;
    t  = ws;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_injector.md
Name: noc_injector

Overview:
- Clocked network interface that packetizes words from a synchronous producer and injects them as flits into the switch's local input port.
- Upstream side: valid/ready stream in the `clk` domain.
- Downstream side: 2-phase bundled-data handshake (`req_o` toggles, `ack_i` toggles) carrying `Data_o`.
- One instance per tile, placed directly upstream of the switch's local port (`PORTS_G` index).

Parameters:
- WIDTH, 64, flit width in bits; must equal the switch WIDTH.
- LocationX, 2, source tile X coordinate inserted in head flits.
- LocationY, 2, source tile Y coordinate inserted in head flits.
- MAX_FLITS, 16, maximum flits per packet including the head; range 2..255.
- SYNC_STAGES, 2, flip-flop depth of the `ack_i` synchronizer; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- gen_enable  input  1  injection enable; when low, no new packet is started.
- s_valid  input  1  producer word valid.
- s_ready  output  1  injector accepts the word this cycle.
- s_data  input  WIDTH-2  payload word.
- s_last  input  1  final payload word of the packet.
- dest_x  input  4  destination X; sampled with the first word of a packet.
- dest_y  input  4  destination Y; sampled with the first word of a packet.
- req_o  output  1  2-phase request to the switch.
- Data_o  output  WIDTH  flit bundled with `req_o`.
- ack_i  input  1  2-phase acknowledge from the switch; asynchronous to `clk`.

Behaviour:
- Flit format:
  - `Data_o[WIDTH-1:WIDTH-2]` is the flit type: 01 head, 00 body, 10 tail.
  - Head payload, from bit WIDTH-3 downward: dest_x[3:0], dest_y[3:0], src X[3:0], src Y[3:0]; remaining bits zero.
  - Body and tail flits carry `s_data` in `[WIDTH-3:0]`.
  - Every packet has a head and at least one body/tail flit.
- Reset values: `req_o`=0, `Data_o`=0, `s_ready`=0, state IDLE, synchronizer flops=0, flit counter=0.
- Handshake:
  - A flit is outstanding while `req_o` != `ack_sync`.
  - `Data_o` is registered one cycle before `req_o` toggles and is held stable until `ack_sync` equals `req_o`. This is the bundled-data setup guarantee.
  - `ack_i` is used only through the synchronizer, never combinationally.
- FSM:
  - IDLE
    - `s_ready`=0.
    - If `gen_enable` && `s_valid`: latch dest_x/dest_y, load head flit into `Data_o`, go to SEND_H.
  - SEND_H: toggle `req_o`, go to WAIT.
  - WAIT
    - When `ack_sync`==`req_o`: go to LOAD if the packet is not finished, else go to IDLE.
    - Flits are never overlapped.
  - LOAD
    - `s_ready`=1 for exactly one cycle when `s_valid`=1.
    - Load a body flit, or a tail flit if `s_last`=1 or the counter equals MAX_FLITS-1.
    - Go to SEND_B.
    - If `s_valid`=0, stay in LOAD; `req_o` is held.
  - SEND_B: toggle `req_o`, increment the counter, go to WAIT.
- Latency:
  - Word accepted to `req_o` toggle: 1 cycle.
  - `ack_i` toggle to next `s_ready`: SYNC_STAGES+1 cycles.
- Forced tail:
  - When the counter reaches MAX_FLITS-1, the word is sent as a tail even if `s_last`=0.
  - The next accepted word then begins a new packet, with dest re-sampled.
- `gen_enable` deasserted mid-packet: the current packet completes; only new packet starts are blocked.
- `s_last` on the first word: head flit, then that word as the tail (2 flits).
- Reset mid-packet:
  - All state clears immediately and `req_o` returns to 0.
  - The switch is reset concurrently via its shared `reset`; no partial packet recovery.
- Synchronizer phase mismatch after reset cannot occur, because both sides reset to 0.

Optional Feature:
- Macro: NOC_INJECTOR_STATS_EN.
- When defined, adds three outputs:
  - `stat_pkts` [31:0]: increments on each tail handshake completion.
  - `stat_flits` [31:0]: increments on each completed handshake.
  - `stat_stall` [31:0]: increments each cycle in WAIT.
- All three counters are cleared by `reset` and saturate at all-ones.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `noc_pkg`:
  - `flit_type_t` enum (HEAD=2'b01, BODY=2'b00, TAIL=2'b10).
  - Head-field offset and width localparams (COORD_W=4).
  - `inj_state_t` enum (IDLE, SEND_H, WAIT, LOAD, SEND_B).
- Sub-module `sync_ff`: parameterized SYNC_STAGES flop chain with async active-high reset, used for `ack_i`.

Test Plan:
- Single packet: dest (1,3), 3 words A,B,C with `s_last` on C. Required: flits head(type 01, dest 1/3, src 2/2), A(00), B(00), C(10). Exactly 4 `req_o` toggles. `Data_o` stable between each toggle and its ack.
- Slow ack: ack model delays 20 cycles. Required: `s_ready` stays low and `Data_o` unchanged throughout; next flit starts SYNC_STAGES+1 cycles after the ack toggle.
- Forced tail: MAX_FLITS=4, 7 words with no `s_last`. Required: first packet is head + 3 flits, the third typed tail; second packet starts with a new head and re-sampled dest.
- `gen_enable` low with `s_valid` high: no `req_o` toggle. Dropping `gen_enable` mid-packet: the packet still completes with its tail.
- Reset asserted in WAIT: `req_o`=0, `Data_o`=0 and `s_ready`=0 immediately. After release, a new packet proceeds normally.
- With NOC_INJECTOR_STATS_EN: two packets of 3 and 5 flits. Required: `stat_pkts`=2, `stat_flits`=8, `stat_stall` equals the total WAIT cycles counted by the bench.
